mig_app_arbiter: RTL and testbench

MIG_APP_ARBITER -- requirements
Module: mig_app_arbiter

---
 rtl/mig_app_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mig_app_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_app_arbiter.sv
// Write/read requester arbiter in front of a MIG native app interface.
// Round-robin on ties, read issue throttled by the outstanding-read count, MIG-side outputs registered.
module mig_app_arbiter #(
    parameter  int unsigned MAX_RD_OUT = 8,
    localparam int unsigned ADDR_W     = 29,
    localparam int unsigned DATA_W     = 256,
    localparam int unsigned MASK_W     = 32,
    localparam int unsigned CNT_W      = 4
) (
    input  logic              ui_clk,
    input  logic              ui_clk_sync_rst,
    input  logic              init_calib_complete,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ack,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_ack,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic [CNT_W-1:0]  rd_outstanding,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [MASK_W-1:0] app_wdf_mask,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid
);

    localparam logic [2:0]        CMD_WR     = 3'b000;
    localparam logic [2:0]        CMD_RD     = 3'b001;
    localparam logic [CNT_W-1:0]  RD_LIMIT   = CNT_W'(MAX_RD_OUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [ADDR_W-1:0] BURST_MASK = ~ADDR_W'(7);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WR, S_RD} state_t;

    state_t              state, state_d;
    logic                wr_first, wr_first_d;
    logic                app_en_d, app_wdf_wren_d, app_wdf_end_d;
    logic [ADDR_W-1:0]   app_addr_d;
    logic [2:0]          app_cmd_d;
    logic [DATA_W-1:0]   app_wdf_data_d;
    logic                w_ack_d, r_ack_d;
    logic [CNT_W-1:0]    rd_outstanding_d;

    logic rd_elig_c, grant_w_c, grant_r_c;
    logic wr_cmd_done_c, wr_data_done_c, rd_accept_c;

    // Arbitration: wr_first set means the write side wins the next tie
    assign rd_elig_c      = r_req && (rd_outstanding < RD_LIMIT);
    assign grant_w_c      = (state == S_IDLE) && init_calib_complete && w_req &&
                            (!rd_elig_c || wr_first);
    assign grant_r_c      = (state == S_IDLE) && init_calib_complete && rd_elig_c &&
                            (!w_req || !wr_first);
    assign wr_cmd_done_c  = !app_en || app_rdy;
    assign wr_data_done_c = !app_wdf_wren || app_wdf_rdy;
    assign rd_accept_c    = (state == S_RD) && app_en && app_rdy;

    assign app_wdf_mask   = '0;

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) state <= S_INIT;
        else                 state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_INIT: if (init_calib_complete) state_d = S_IDLE;
            S_IDLE: begin
                if (!init_calib_complete) state_d = S_INIT;
                else if (grant_w_c)       state_d = S_WR;
                else if (grant_r_c)       state_d = S_RD;
            end
            S_WR:   if (wr_cmd_done_c && wr_data_done_c) state_d = S_IDLE;
            S_RD:   if (rd_accept_c) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Next values of the registered MIG-side and ack outputs
    always_comb begin
        app_en_d       = app_en;
        app_wdf_wren_d = app_wdf_wren;
        app_wdf_end_d  = app_wdf_end;
        app_addr_d     = app_addr;
        app_cmd_d      = app_cmd;
        app_wdf_data_d = app_wdf_data;
        w_ack_d        = 1'b0;
        r_ack_d        = 1'b0;
        wr_first_d     = wr_first;
        case (state)
            S_IDLE: begin
                if (grant_w_c) begin
                    app_en_d       = 1'b1;
                    app_wdf_wren_d = 1'b1;
                    app_wdf_end_d  = 1'b1;
                    app_cmd_d      = CMD_WR;
                    app_addr_d     = w_addr & BURST_MASK;
                    app_wdf_data_d = w_data;
                    wr_first_d     = 1'b0;
                end else if (grant_r_c) begin
                    app_en_d       = 1'b1;
                    app_cmd_d      = CMD_RD;
                    app_addr_d     = r_addr & BURST_MASK;
                    wr_first_d     = 1'b1;
                end
            end
            S_WR: begin
                // Command and data channels retire independently
                if (app_en && app_rdy) app_en_d = 1'b0;
                if (app_wdf_wren && app_wdf_rdy) begin
                    app_wdf_wren_d = 1'b0;
                    app_wdf_end_d  = 1'b0;
                end
                if (wr_cmd_done_c && wr_data_done_c) w_ack_d = 1'b1;
            end
            S_RD: begin
                if (rd_accept_c) begin
                    app_en_d = 1'b0;
                    r_ack_d  = 1'b1;
                end
            end
            default: begin
                app_en_d       = 1'b0;
                app_wdf_wren_d = 1'b0;
                app_wdf_end_d  = 1'b0;
            end
        endcase
    end

    // Outstanding reads: saturating, beats with nothing outstanding are not counted
    always_comb begin
        rd_outstanding_d = rd_outstanding;
        if (rd_accept_c && !app_rd_data_valid) begin
            if (rd_outstanding != CNT_MAX) rd_outstanding_d = rd_outstanding + CNT_W'(1);
        end else if (!rd_accept_c && app_rd_data_valid) begin
            if (rd_outstanding != '0) rd_outstanding_d = rd_outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            app_en         <= 1'b0;
            app_wdf_wren   <= 1'b0;
            app_wdf_end    <= 1'b0;
            app_addr       <= '0;
            app_cmd        <= '0;
            app_wdf_data   <= '0;
            w_ack          <= 1'b0;
            r_ack          <= 1'b0;
            r_valid        <= 1'b0;
            r_data         <= '0;
            rd_outstanding <= '0;
            wr_first       <= 1'b1;
        end else begin
            app_en         <= app_en_d;
            app_wdf_wren   <= app_wdf_wren_d;
            app_wdf_end    <= app_wdf_end_d;
            app_addr       <= app_addr_d;
            app_cmd        <= app_cmd_d;
            app_wdf_data   <= app_wdf_data_d;
            w_ack          <= w_ack_d;
            r_ack          <= r_ack_d;
            r_valid        <= app_rd_data_valid;
            r_data         <= app_rd_data;
            rd_outstanding <= rd_outstanding_d;
            wr_first       <= wr_first_d;
        end
    end

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Randomized bench for mig_app_arbiter with a transaction-level model of grants,
// outstanding reads and the forwarded read-data stream.
module tb_mig_app_arbiter;

    localparam int MAX_RD = 2;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    logic         ui_clk;
    logic         ui_clk_sync_rst;
    logic         init_calib_complete;
    logic         w_req;
    logic [28:0]  w_addr;
    logic [255:0] w_data;
    logic         w_ack;
    logic         r_req;
    logic [28:0]  r_addr;
    logic         r_ack;
    logic [255:0] r_data;
    logic         r_valid;
    logic [3:0]   rd_outstanding;
    logic [28:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic [255:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic [31:0]  app_wdf_mask;
    logic         app_rdy;
    logic         app_wdf_rdy;
    logic [255:0] app_rd_data;
    logic         app_rd_data_valid;

    int total = 0;
    int bad   = 0;
    int out_m = 0;
    bit last_w = 1'b0;
    logic [255:0] exp_q[$];
    logic [255:0] obs_q[$];

    mig_app_arbiter #(.MAX_RD_OUT(MAX_RD)) dut (
        .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst),
        .init_calib_complete(init_calib_complete),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ack(w_ack),
        .r_req(r_req), .r_addr(r_addr), .r_ack(r_ack),
        .r_data(r_data), .r_valid(r_valid), .rd_outstanding(rd_outstanding),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [28:0] rand_addr();
        return 29'($urandom());
    endfunction

    // Advance one cycle and keep the reference model in step with the bus
    task automatic step();
        bit acc, ret;
        acc = app_en && (app_cmd == CMD_RD) && app_rdy && !ui_clk_sync_rst;
        ret = app_rd_data_valid && !ui_clk_sync_rst;
        if (ret) exp_q.push_back(app_rd_data);
        if (ui_clk_sync_rst)   out_m = 0;
        else if (acc && !ret)  out_m = (out_m < 15) ? out_m + 1 : 15;
        else if (ret && !acc && out_m > 0) out_m = out_m - 1;
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        if (r_valid) obs_q.push_back(r_data);
    endtask

    task automatic test_reset();
        ui_clk_sync_rst = 1'b1;
        step(); step();
        total++; if ({app_en, app_wdf_wren, app_wdf_end} !== 3'b000) begin bad++;
            $display("FAIL reset_enables got=%b want=000", {app_en, app_wdf_wren, app_wdf_end}); end
        total++; if (app_addr !== 29'h0 || app_cmd !== 3'h0) begin bad++;
            $display("FAIL reset_addr_cmd got=%h/%h want=0/0", app_addr, app_cmd); end
        total++; if (app_wdf_data !== 256'h0) begin bad++;
            $display("FAIL reset_wdf_data got=%h want=0", app_wdf_data); end
        total++; if ({w_ack, r_ack, r_valid} !== 3'b000) begin bad++;
            $display("FAIL reset_acks got=%b want=000", {w_ack, r_ack, r_valid}); end
        total++; if (r_data !== 256'h0 || rd_outstanding !== 4'h0) begin bad++;
            $display("FAIL reset_rdata_cnt got=%h/%0d want=0/0", r_data, rd_outstanding); end
        total++; if (app_wdf_mask !== 32'h0) begin bad++;
            $display("FAIL reset_mask got=%h want=0", app_wdf_mask); end
        ui_clk_sync_rst = 1'b0;
    endtask

    task automatic test_calib_gate();
        logic [255:0] wd;
        int en_seen;
        wd = rand256(); en_seen = 0;
        w_addr = 29'h45; w_data = wd; w_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (app_en) en_seen++;
        end
        total++; if (en_seen != 0) begin bad++;
            $display("FAIL calib_hold_en got=%0d want=0", en_seen); end
        init_calib_complete = 1'b1;
        step();
        total++; if (app_en !== 1'b0) begin bad++;
            $display("FAIL calib_first_cycle_en got=%b want=0", app_en); end
        step();
        total++; if (app_en !== 1'b1 || app_cmd !== CMD_WR) begin bad++;
            $display("FAIL calib_grant got=%b/%h want=1/0", app_en, app_cmd); end
        total++; if (app_addr !== 29'h40 || app_wdf_data !== wd) begin bad++;
            $display("FAIL calib_wr_payload got=%h want=40", app_addr); end
        total++; if ({app_wdf_wren, app_wdf_end} !== 2'b11) begin bad++;
            $display("FAIL calib_wren got=%b want=11", {app_wdf_wren, app_wdf_end}); end
        last_w = 1'b1;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        step();
        total++; if ({w_ack, app_en, app_wdf_wren} !== 3'b100) begin bad++;
            $display("FAIL calib_wack got=%b want=100", {w_ack, app_en, app_wdf_wren}); end
        w_req = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        step();
        total++; if (w_ack !== 1'b0) begin bad++;
            $display("FAIL calib_wack_pulse got=%b want=0", w_ack); end
    endtask

    task automatic test_write_stall();
        logic [255:0] wd, cap_data;
        logic [28:0]  cap_addr;
        int g, en_cyc, wren_cyc, ack_cnt, ack_k;
        wd = rand256(); g = -1; en_cyc = 0; wren_cyc = 0; ack_cnt = 0; ack_k = -1;
        cap_addr = '0; cap_data = '0;
        w_addr = 29'h1F; w_data = wd; w_req = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (g < 0 && app_en) begin g = i; cap_addr = app_addr; cap_data = app_wdf_data; end
            if (app_en) en_cyc++;
            if (app_wdf_wren) wren_cyc++;
            if (w_ack) begin ack_cnt++; ack_k = i - g; w_req = 1'b0; end
            app_wdf_rdy = (g >= 0) && (i - g == 3);
        end
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; last_w = 1'b1;
        total++; if (g < 0 || cap_addr !== 29'h18 || cap_data !== wd) begin bad++;
            $display("FAIL stall_payload got=%h (g=%0d) want=18", cap_addr, g); end
        total++; if (en_cyc != 1) begin bad++;
            $display("FAIL stall_en_cycles got=%0d want=1", en_cyc); end
        total++; if (wren_cyc != 4) begin bad++;
            $display("FAIL stall_wren_cycles got=%0d want=4", wren_cyc); end
        total++; if (ack_cnt != 1 || ack_k != 4) begin bad++;
            $display("FAIL stall_wack got=%0d@%0d want=1@4", ack_cnt, ack_k); end
    endtask

    task automatic test_round_robin();
        logic [28:0]  wa, ra;
        logic [255:0] wd;
        int wacks, racks, grants, order_err, cnt_err;
        bit exp_w, pw, pr, prev_en, drain;
        wacks = 0; racks = 0; grants = 0; order_err = 0; cnt_err = 0;
        wa = rand_addr(); ra = rand_addr(); wd = rand256();
        w_addr = wa; w_data = wd; r_addr = ra; w_req = 1'b1; r_req = 1'b1;
        prev_en = app_en; pw = 1'b0; pr = 1'b0;
        for (int i = 0; i < 460; i++) begin
            drain = (i >= 400);
            if (app_en && !prev_en) begin
                exp_w = (pw && pr) ? !last_w : pw;
                grants++;
                if (app_cmd !== (exp_w ? CMD_WR : CMD_RD) ||
                    app_addr !== ((exp_w ? wa : ra) & ~29'h7) ||
                    (exp_w && app_wdf_data !== wd)) begin
                    order_err++;
                    if (order_err == 1) $display("FAIL rr_grant got=%h/%h want_w=%b", app_cmd, app_addr, exp_w);
                end
                last_w = exp_w;
            end
            prev_en = app_en;
            if (rd_outstanding !== 4'(out_m)) cnt_err++;
            if (w_ack) begin
                wacks++;
                if (drain) w_req = 1'b0;
                else begin wa = rand_addr(); wd = rand256(); w_addr = wa; w_data = wd; end
            end
            if (r_ack) begin
                racks++;
                if (drain) r_req = 1'b0;
                else begin ra = rand_addr(); r_addr = ra; end
            end
            app_rdy     = drain ? 1'b1 : 1'($urandom_range(0, 1));
            app_wdf_rdy = drain ? 1'b1 : 1'($urandom_range(0, 1));
            if (out_m > 0) begin app_rd_data = rand256(); app_rd_data_valid = 1'b1; end
            pw = w_req; pr = r_req && (out_m < MAX_RD);
            step();
        end
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        total++; if (order_err != 0) begin bad++;
            $display("FAIL rr_order got=%0d errors want=0", order_err); end
        total++; if (cnt_err != 0) begin bad++;
            $display("FAIL rr_outstanding got=%0d mismatching cycles want=0", cnt_err); end
        total++; if (grants < 40 || wacks + racks != grants) begin bad++;
            $display("FAIL rr_ack_total got=%0d acks/%0d grants want equal and >=40", wacks + racks, grants); end
        total++; if (wacks - racks > 1 || racks - wacks > 1) begin bad++;
            $display("FAIL rr_balance got=w%0d/r%0d want within 1", wacks, racks); end
    endtask

    task automatic test_rd_limit();
        int racks;
        bit got;
        racks = 0;
        r_addr = rand_addr(); r_req = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (r_ack) begin racks++; r_addr = rand_addr(); end
        end
        total++; if (racks != 2) begin bad++;
            $display("FAIL limit_racks got=%0d want=2", racks); end
        total++; if (rd_outstanding !== 4'd2) begin bad++;
            $display("FAIL limit_count got=%0d want=2", rd_outstanding); end
        w_addr = rand_addr(); w_data = rand256(); w_req = 1'b1; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (r_ack) racks++;
            if (w_ack) begin got = 1'b1; w_req = 1'b0; end
        end
        total++; if (!got || racks != 2) begin bad++;
            $display("FAIL limit_write_pass got=%b/%0d want=1/2", got, racks); end
        app_rd_data = rand256(); app_rd_data_valid = 1'b1;
        step();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (r_ack) begin got = 1'b1; r_req = 1'b0; end
        end
        total++; if (!got || rd_outstanding !== 4'd2) begin bad++;
            $display("FAIL limit_third_read got=%b/%0d want=1/2", got, rd_outstanding); end
        for (int i = 0; i < 2; i++) begin
            app_rd_data = rand256(); app_rd_data_valid = 1'b1;
            step();
        end
        total++; if (rd_outstanding !== 4'd0) begin bad++;
            $display("FAIL limit_drain got=%0d want=0", rd_outstanding); end
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; last_w = 1'b0;
    endtask

    task automatic test_same_cycle();
        logic [255:0] d;
        bit got;
        d = rand256(); app_rd_data = d; app_rd_data_valid = 1'b1;
        step();
        total++; if (r_valid !== 1'b1 || r_data !== d || rd_outstanding !== 4'd0) begin bad++;
            $display("FAIL orphan_beat got=%b/%0d want=1/0", r_valid, rd_outstanding); end
        r_addr = rand_addr(); r_req = 1'b1; app_rdy = 1'b1; got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (r_ack) begin got = 1'b1; r_req = 1'b0; end
        end
        total++; if (!got || rd_outstanding !== 4'd1) begin bad++;
            $display("FAIL same_setup got=%b/%0d want=1/1", got, rd_outstanding); end
        app_rdy = 1'b0; r_addr = rand_addr(); r_req = 1'b1; got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (app_en === 1'b1 && app_cmd === CMD_RD) got = 1'b1;
        end
        total++; if (!got) begin bad++;
            $display("FAIL same_grant_timeout got=0 want=1"); end
        d = rand256(); app_rd_data = d; app_rd_data_valid = 1'b1; app_rdy = 1'b1;
        step();
        r_req = 1'b0; app_rdy = 1'b0;
        total++; if (r_ack !== 1'b1 || rd_outstanding !== 4'd1) begin bad++;
            $display("FAIL same_cycle_count got=%b/%0d want=1/1", r_ack, rd_outstanding); end
        total++; if (r_valid !== 1'b1 || r_data !== d) begin bad++;
            $display("FAIL same_cycle_data got=%b/%h want=1/%h", r_valid, r_data, d); end
        app_rd_data = rand256(); app_rd_data_valid = 1'b1;
        step();
        total++; if (rd_outstanding !== 4'd0) begin bad++;
            $display("FAIL same_drain got=%0d want=0", rd_outstanding); end
        last_w = 1'b0;
    endtask

    task automatic test_calib_drop();
        bit got;
        int seen;
        w_addr = rand_addr(); w_data = rand256(); w_req = 1'b1;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; got = 1'b0; seen = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (app_en === 1'b1) got = 1'b1;
        end
        init_calib_complete = 1'b0;
        step(); step();
        total++; if (!got || {app_en, app_wdf_wren} !== 2'b11) begin bad++;
            $display("FAIL drop_inflight got=%b/%b want=1/11", got, {app_en, app_wdf_wren}); end
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        step();
        total++; if (w_ack !== 1'b1) begin bad++;
            $display("FAIL drop_wack got=%b want=1", w_ack); end
        w_addr = rand_addr(); w_data = rand256();
        for (int i = 0; i < 5; i++) begin
            step();
            if (app_en) seen++;
        end
        total++; if (seen != 0) begin bad++;
            $display("FAIL drop_to_init got=%0d grants want=0", seen); end
        init_calib_complete = 1'b1; got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (w_ack) begin got = 1'b1; w_req = 1'b0; end
        end
        total++; if (!got) begin bad++;
            $display("FAIL drop_recover got=0 want=1"); end
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; last_w = 1'b1;
    endtask

    task automatic test_reset_mid_wr();
        bit got;
        int acks;
        w_addr = rand_addr(); w_data = rand256(); w_req = 1'b1;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; got = 1'b0; acks = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (app_en === 1'b1) got = 1'b1;
        end
        total++; if (!got) begin bad++;
            $display("FAIL rstwr_grant_timeout got=0 want=1"); end
        #2 ui_clk_sync_rst = 1'b1;
        #1;
        total++; if ({app_en, app_wdf_wren, app_wdf_end} !== 3'b000) begin bad++;
            $display("FAIL rstwr_async_en got=%b want=000", {app_en, app_wdf_wren, app_wdf_end}); end
        total++; if (app_addr !== 29'h0 || app_cmd !== 3'h0 || app_wdf_data !== 256'h0) begin bad++;
            $display("FAIL rstwr_async_payload got=%h/%h want=0/0", app_addr, app_cmd); end
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (w_ack) acks++;
        end
        ui_clk_sync_rst = 1'b0;
        app_rd_data = rand256(); app_rd_data_valid = 1'b1;
        step();
        if (w_ack) acks++;
        total++; if (app_en !== 1'b0 || rd_outstanding !== 4'd0) begin bad++;
            $display("FAIL rstwr_init got=%b/%0d want=0/0", app_en, rd_outstanding); end
        step();
        if (w_ack) acks++;
        total++; if (acks != 0 || app_en !== 1'b1) begin bad++;
            $display("FAIL rstwr_regrant got=%0d acks/en=%b want=0/1", acks, app_en); end
        step();
        total++; if (w_ack !== 1'b1) begin bad++;
            $display("FAIL rstwr_complete got=%b want=1", w_ack); end
        w_req = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        step(); step();
    endtask

    task automatic test_read_forwarding();
        int errs;
        errs = 0;
        total++; if (obs_q.size() != exp_q.size()) begin bad++;
            $display("FAIL fwd_beats got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) errs++;
        total++; if (errs != 0 || exp_q.size() == 0) begin bad++;
            $display("FAIL fwd_order got=%0d wrong of %0d want=0", errs, exp_q.size()); end
    endtask

    initial begin
        ui_clk_sync_rst = 1'b1; init_calib_complete = 1'b0;
        w_req = 1'b0; w_addr = '0; w_data = '0; r_req = 1'b0; r_addr = '0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
        test_reset();
        test_calib_gate();
        test_write_stall();
        test_round_robin();
        test_rd_limit();
        test_same_cycle();
        test_calib_drop();
        test_reset_mid_wr();
        test_read_forwarding();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
